id_ex_hazard_register: RTL

- ID/EX pipeline register with integrated load-use hazard detection.
- Captures decoded operands and control from ID each cycle.
- Presents the registered RS, RT, RD and REGWRITE fields consumed by the EX-stage operand-forwarding logic.
- Forwarding cannot cover a load result needed by the next instruction, so this block asserts STALL to freeze PC and IF/ID and inserts a bubble into EX. It also accepts a branch FLUSH.

---
 rtl/id_ex_hazard_register.sv | 114 +++++++++++
 1 files changed

// File: rtl/id_ex_hazard_register.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and
// saturating stall/flush event counters.
module id_ex_hazard_register #(
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ID_VALID,
  input  logic [4:0]         IF_ID_RS,
  input  logic [4:0]         IF_ID_RT,
  input  logic [4:0]         ID_RD,
  input  logic               ID_USES_RS,
  input  logic               ID_USES_RT,
  input  logic               ID_REGWRITE,
  input  logic               ID_MEMREAD,
  input  logic               ID_MEMWRITE,
  input  logic               ID_MEMTOREG,
  input  logic               ID_ALUSRC,
  input  logic [ALUOP_W-1:0] ID_ALUOP,
  input  logic [DATA_W-1:0]  ID_READ_DATA_1,
  input  logic [DATA_W-1:0]  ID_READ_DATA_2,
  input  logic [DATA_W-1:0]  ID_IMM,
  input  logic               FLUSH,
  output logic               ID_EX_VALID,
  output logic [4:0]         ID_EX_RS,
  output logic [4:0]         ID_EX_RT,
  output logic [4:0]         ID_EX_RD,
  output logic               ID_EX_REGWRITE,
  output logic               ID_EX_MEMREAD,
  output logic               ID_EX_MEMWRITE,
  output logic               ID_EX_MEMTOREG,
  output logic               ID_EX_ALUSRC,
  output logic [ALUOP_W-1:0] ID_EX_ALUOP,
  output logic [DATA_W-1:0]  ID_EX_DATA_1,
  output logic [DATA_W-1:0]  ID_EX_DATA_2,
  output logic [DATA_W-1:0]  ID_EX_IMM,
  output logic               STALL,
  output logic [CNT_W-1:0]   STALL_COUNT,
  output logic [CNT_W-1:0]   FLUSH_COUNT
);

  typedef enum logic [1:0] {
    ACT_CAPTURE,
    ACT_FLUSH,
    ACT_STALL
  } action_t;

  logic    rs_hit;
  logic    rt_hit;
  logic    hz;
  action_t action;

  always_comb begin
    rs_hit = ID_USES_RS && (IF_ID_RS == ID_EX_RD);
    rt_hit = ID_USES_RT && (IF_ID_RT == ID_EX_RD);
    hz     = ID_VALID && ID_EX_VALID && ID_EX_MEMREAD && (ID_EX_RD != 5'd0)
             && (rs_hit || rt_hit);
    STALL  = hz && !FLUSH;
  end

  // Flush outranks the hazard: the squashed ID instruction needs no stall.
  always_comb begin
    action = ACT_CAPTURE;
    if (FLUSH)   action = ACT_FLUSH;
    else if (hz) action = ACT_STALL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || action != ACT_CAPTURE) begin
      ID_EX_VALID    <= 1'b0;
      ID_EX_RS       <= '0;
      ID_EX_RT       <= '0;
      ID_EX_RD       <= '0;
      ID_EX_REGWRITE <= 1'b0;
      ID_EX_MEMREAD  <= 1'b0;
      ID_EX_MEMWRITE <= 1'b0;
      ID_EX_MEMTOREG <= 1'b0;
      ID_EX_ALUSRC   <= 1'b0;
      ID_EX_ALUOP    <= '0;
      ID_EX_DATA_1   <= '0;
      ID_EX_DATA_2   <= '0;
      ID_EX_IMM      <= '0;
    end else begin
      ID_EX_VALID    <= ID_VALID;
      ID_EX_RS       <= IF_ID_RS;
      ID_EX_RT       <= IF_ID_RT;
      ID_EX_RD       <= ID_RD;
      ID_EX_REGWRITE <= ID_REGWRITE;
      ID_EX_MEMREAD  <= ID_MEMREAD;
      ID_EX_MEMWRITE <= ID_MEMWRITE;
      ID_EX_MEMTOREG <= ID_MEMTOREG;
      ID_EX_ALUSRC   <= ID_ALUSRC;
      ID_EX_ALUOP    <= ID_ALUOP;
      ID_EX_DATA_1   <= ID_READ_DATA_1;
      ID_EX_DATA_2   <= ID_READ_DATA_2;
      ID_EX_IMM      <= ID_IMM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      STALL_COUNT <= '0;
      FLUSH_COUNT <= '0;
    end else begin
      if (action == ACT_STALL && STALL_COUNT != '1)
        STALL_COUNT <= STALL_COUNT + 1'b1;
      if (action == ACT_FLUSH && FLUSH_COUNT != '1)
        FLUSH_COUNT <= FLUSH_COUNT + 1'b1;
    end
  end

endmodule
